// File: rtl/acl_regs_pkg.sv
// acl_regs_pkg: register map, FSM states and widths for the PmodACL SPI responder.
package acl_regs_pkg;
    localparam int AXIS_W = 10;
    localparam int ADDR_W = 6;
    localparam logic [ADDR_W-1:0] DEVID       = 6'h00;
    localparam logic [ADDR_W-1:0] OFSX        = 6'h1E;
    localparam logic [ADDR_W-1:0] OFSY        = 6'h1F;
    localparam logic [ADDR_W-1:0] OFSZ        = 6'h20;
    localparam logic [ADDR_W-1:0] POWER_CTL   = 6'h2D;
    localparam logic [ADDR_W-1:0] DATA_FORMAT = 6'h31;
    localparam logic [ADDR_W-1:0] DATAX0      = 6'h32;
    localparam logic [ADDR_W-1:0] DATAX1      = 6'h33;
    localparam logic [ADDR_W-1:0] DATAY0      = 6'h34;
    localparam logic [ADDR_W-1:0] DATAY1      = 6'h35;
    localparam logic [ADDR_W-1:0] DATAZ0      = 6'h36;
    localparam logic [ADDR_W-1:0] DATAZ1      = 6'h37;
    typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;
    function automatic logic [7:0] axis_hi(input logic [AXIS_W-1:0] v);
        return {{6{v[AXIS_W-1]}}, v[AXIS_W-1:8]};
    endfunction
endpackage

// File: rtl/spi_edge_sync.sv
// spi_edge_sync: 2-FF synchronizer for an asynchronous SPI pin plus rise/fall detection.
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    logic [2:0] s_q;
    // Clearing to 0 means a select held low across reset never looks like a fresh frame start.
    always_ff @(posedge clk) begin
        if (!rst_n) s_q <= 3'b000;
        else        s_q <= {s_q[1:0], d_i};
    end
    assign level_o = s_q[1];
    assign rise_o  = s_q[1] & ~s_q[2];
    assign fall_o  = ~s_q[1] & s_q[2];
endmodule

// File: rtl/acl_spi_responder.sv
// acl_spi_responder: SPI mode-3 slave modelling the PmodACL accelerometer register map.
module acl_spi_responder
    import acl_regs_pkg::*;
#(
    parameter logic [7:0] DEVID_VAL = 8'hE5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SCLK,
    input  logic        SS,
    input  logic        SDI,
    output logic        SDO,
    input  logic [9:0]  xAxis,
    input  logic [9:0]  yAxis,
    input  logic [9:0]  zAxis,
    output logic [7:0]  powerCtl,
    output logic [7:0]  dataFormat,
    output logic        wrStrobe,
    output logic [5:0]  wrAddr,
    output logic [7:0]  wrData
);
    logic sclk_lvl, sclk_rise, sclk_fall, ss_lvl, ss_rise, ss_fall, sdi_lvl, sdi_rise, sdi_fall;
    logic unused_edges;

    spi_edge_sync u_sclk (.clk(CLK), .rst_n(RST), .d_i(SCLK), .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));
    spi_edge_sync u_ss   (.clk(CLK), .rst_n(RST), .d_i(SS),   .level_o(ss_lvl),   .rise_o(ss_rise),   .fall_o(ss_fall));
    spi_edge_sync u_sdi  (.clk(CLK), .rst_n(RST), .d_i(SDI),  .level_o(sdi_lvl),  .rise_o(sdi_rise),  .fall_o(sdi_fall));
    assign unused_edges = ^{sclk_lvl, ss_lvl, sdi_rise, sdi_fall};

    state_e                  state_q, state_d;
    logic [2:0]              bit_q, bit_d;
    logic [6:0]              rx_q, rx_d;
    logic [7:0]              tx_q, tx_d;
    logic                    sdo_q, sdo_d;
    logic                    rw_q, rw_d, mb_q, mb_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [3*AXIS_W-1:0]     shadow_q, shadow_d;
    logic [7:0]              power_q, power_d, fmt_q, fmt_d;
    logic [2:0][7:0]         ofs_q, ofs_d;
    logic                    wr_pend_q, wr_pend_d, wr_strobe_q;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [7:0]              wr_data_q, wr_data_d;
    logic [7:0]              rx_sh, rd_byte;
    logic [ADDR_W-1:0]       ld_addr;

    assign rx_sh   = {rx_q, sdi_lvl};
    // Byte loaded for transmit: the command's start address, or the address after this byte.
    assign ld_addr = (state_q == CMD) ? rx_sh[5:0] : addr_q + {5'd0, mb_q};

    always_comb begin
        rd_byte = 8'h00;
        case (ld_addr)
            DEVID:       rd_byte = DEVID_VAL;
            OFSX:        rd_byte = ofs_q[0];
            OFSY:        rd_byte = ofs_q[1];
            OFSZ:        rd_byte = ofs_q[2];
            POWER_CTL:   rd_byte = power_q;
            DATA_FORMAT: rd_byte = fmt_q;
            DATAX0:      rd_byte = shadow_q[7:0];
            DATAX1:      rd_byte = axis_hi(shadow_q[9:0]);
            DATAY0:      rd_byte = shadow_q[17:10];
            DATAY1:      rd_byte = axis_hi(shadow_q[19:10]);
            DATAZ0:      rd_byte = shadow_q[27:20];
            DATAZ1:      rd_byte = axis_hi(shadow_q[29:20]);
            default:     rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        sdo_d     = sdo_q;
        rw_d      = rw_q;
        mb_d      = mb_q;
        addr_d    = addr_q;
        shadow_d  = shadow_q;
        power_d   = power_q;
        fmt_d     = fmt_q;
        ofs_d     = ofs_q;
        wr_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (ss_rise) begin
            state_d = IDLE;
            sdo_d   = 1'b0;
        end else if (ss_fall) begin
            state_d  = CMD;
            bit_d    = 3'd0;
            sdo_d    = 1'b0;
            shadow_d = {zAxis, yAxis, xAxis};
        end else if (state_q != IDLE && sclk_rise) begin
            rx_d  = rx_sh[6:0];
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7 && state_q == CMD) begin
                state_d = DATA;
                rw_d    = rx_sh[7];
                mb_d    = rx_sh[6];
                addr_d  = rx_sh[5:0];
                tx_d    = rx_sh[7] ? rd_byte : tx_q;
            end else if (bit_q == 3'd7) begin
                addr_d = ld_addr;
                tx_d   = rw_q ? rd_byte : tx_q;
                if (!rw_q) begin
                    wr_pend_d = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = rx_sh;
                    power_d   = (addr_q == POWER_CTL) ? rx_sh : power_q;
                    fmt_d     = (addr_q == DATA_FORMAT) ? rx_sh : fmt_q;
                    if (addr_q >= OFSX && addr_q <= OFSZ) ofs_d[2'(addr_q - OFSX)] = rx_sh;
                end
            end
        end else if (state_q == DATA && rw_q && sclk_fall) begin
            sdo_d = tx_q[7];
            tx_d  = {tx_q[6:0], 1'b0};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= IDLE;
            bit_q       <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'd0;
            sdo_q       <= 1'b0;
            rw_q        <= 1'b0;
            mb_q        <= 1'b0;
            addr_q      <= '0;
            shadow_q    <= '0;
            power_q     <= 8'd0;
            fmt_q       <= 8'd0;
            ofs_q       <= '0;
            wr_pend_q   <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            sdo_q       <= sdo_d;
            rw_q        <= rw_d;
            mb_q        <= mb_d;
            addr_q      <= addr_d;
            shadow_q    <= shadow_d;
            power_q     <= power_d;
            fmt_q       <= fmt_d;
            ofs_q       <= ofs_d;
            wr_pend_q   <= wr_pend_d;
            wr_strobe_q <= wr_pend_q;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign SDO        = sdo_q;
    assign powerCtl   = power_q;
    assign dataFormat = fmt_q;
    assign wrStrobe   = wr_strobe_q;
    assign wrAddr     = wr_addr_q;
    assign wrData     = wr_data_q;
endmodule

// File: tb/tb_acl_spi_responder.sv
// tb_acl_spi_responder: randomized SPI-master stimulus with a register-map reference model and scoreboard.
module tb_acl_spi_responder;
    localparam int H = 8;
    logic       CLK = 1'b0, RST = 1'b0, SCLK = 1'b1, SS = 1'b1, SDI = 1'b0;
    logic       SDO, wrStrobe;
    logic [9:0] xAxis = '0, yAxis = '0, zAxis = '0;
    logic [7:0] powerCtl, dataFormat, wrData;
    logic [5:0] wrAddr;

    acl_spi_responder dut (
        .CLK(CLK), .RST(RST), .SCLK(SCLK), .SS(SS), .SDI(SDI), .SDO(SDO),
        .xAxis(xAxis), .yAxis(yAxis), .zAxis(zAxis),
        .powerCtl(powerCtl), .dataFormat(dataFormat),
        .wrStrobe(wrStrobe), .wrAddr(wrAddr), .wrData(wrData)
    );

    always #5 CLK = ~CLK;

    int          vectors = 0, errors = 0;
    logic [7:0]  mem [64];
    logic [7:0]  mon_pc = 8'h00, mon_df = 8'h00;
    logic [7:0]  exp_rd [$];
    logic [13:0] exp_wr [$];
    logic [7:0]  dq [$];
    bit          mon_skip = 1'b0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic bit writable(input logic [5:0] a);
        return a inside {6'h1E, 6'h1F, 6'h20, 6'h2D, 6'h31};
    endfunction

    // Register map as seen by a master: device id, stored registers, axis bytes, zero elsewhere.
    function automatic logic [7:0] ref_read(input logic [5:0] a);
        logic [9:0] v;
        int s;
        if (a == 6'h00) return 8'hE5;
        if (writable(a)) return mem[a];
        if (a >= 6'h32 && a <= 6'h37) begin
            v = (a < 6'h34) ? xAxis : (a < 6'h36) ? yAxis : zAxis;
            s = int'($signed(v));
            return a[0] ? 8'(s >>> 8) : v[7:0];
        end
        return 8'h00;
    endfunction

    task automatic do_reset();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_SDO", 16'(SDO), 16'h0);
        chk("rst_powerCtl", 16'(powerCtl), 16'h0);
        chk("rst_dataFormat", 16'(dataFormat), 16'h0);
        chk("rst_wrStrobe", 16'(wrStrobe), 16'h0);
        chk("rst_wrAddr", 16'(wrAddr), 16'h0);
        chk("rst_wrData", 16'(wrData), 16'h0);
        RST = 1'b1;
        foreach (mem[i]) mem[i] = 8'h00;
        mon_pc = 8'h00;
        mon_df = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input int nbits, input int rst_at);
        for (int k = 0; k < nbits; k++) begin
            if (k == rst_at) do_reset();
            SCLK = 1'b0;
            SDI  = b[7-k];
            repeat (H) @(negedge CLK);
            SCLK = 1'b1;
            repeat (H) @(negedge CLK);
        end
    endtask

    // Drives one frame of cmd + dq bytes; abort_bits/rst_bits >= 0 cut the first data byte short.
    task automatic frame(input logic [7:0] cmd, input int abort_bits, input int rst_bits);
        logic [5:0] a = cmd[5:0];
        int n = dq.size();
        if (abort_bits < 0 && rst_bits < 0) begin
            for (int i = 0; i < n; i++) begin
                if (cmd[7]) exp_rd.push_back(ref_read(a));
                else begin
                    exp_wr.push_back({a, dq[i]});
                    if (writable(a)) mem[a] = dq[i];
                end
                if (cmd[6]) a = a + 6'd1;
            end
        end
        mon_skip = (rst_bits >= 0);
        SS = 1'b0;
        repeat (H) @(negedge CLK);
        send_byte(cmd, 8, -1);
        xAxis = 10'($urandom);
        yAxis = 10'($urandom);
        zAxis = 10'($urandom);
        for (int i = 0; i < n; i++) begin
            send_byte(dq[i], (i == 0 && abort_bits >= 0) ? abort_bits : 8, (i == 0) ? rst_bits : -1);
            if (abort_bits >= 0) break;
        end
        repeat (H) @(negedge CLK);
        SS = 1'b1;
        SDI = 1'b0;
        repeat (3 * H) @(negedge CLK);
        mon_skip = 1'b0;
    endtask

    task automatic fill(input int n);
        dq.delete();
        repeat (n) dq.push_back(8'($urandom));
    endtask

    initial begin : spi_mon
        int nb = 0, bi = 0;
        bit rd = 1'b0;
        logic [7:0] si = 8'h00, so = 8'h00;
        forever begin
            @(posedge SCLK or posedge SS);
            if (SS) begin
                nb = 0;
                bi = 0;
            end else begin
                si = {si[6:0], SDI};
                so = {so[6:0], SDO};
                nb++;
                if (nb == 8) begin
                    nb = 0;
                    if (bi == 0) rd = si[7];
                    else if (!mon_skip) begin
                        if (!rd) chk("sdo_in_write", 16'(so), 16'h0);
                        else if (exp_rd.size() == 0) begin
                            vectors++;
                            errors++;
                            $display("FAIL rd_unexpected got=%h exp=none", so);
                        end else chk("rd_byte", 16'(so), 16'(exp_rd.pop_front()));
                    end
                    bi++;
                end
            end
        end
    end

    always @(negedge CLK) begin
        logic [13:0] e;
        if (RST && wrStrobe) begin
            if (exp_wr.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL wr_unexpected got=%h/%h exp=none", wrAddr, wrData);
            end else begin
                e = exp_wr.pop_front();
                chk("wrAddr", 16'(wrAddr), 16'(e[13:8]));
                chk("wrData", 16'(wrData), 16'(e[7:0]));
                if (e[13:8] == 6'h2D) mon_pc = e[7:0];
                if (e[13:8] == 6'h31) mon_df = e[7:0];
                chk("powerCtl_wr", 16'(powerCtl), 16'(mon_pc));
                chk("dataFormat_wr", 16'(dataFormat), 16'(mon_df));
            end
        end
    end

    initial begin
        logic [5:0] hot [15] = '{6'h00, 6'h1E, 6'h1F, 6'h20, 6'h2D, 6'h31, 6'h32, 6'h33,
                                 6'h34, 6'h35, 6'h36, 6'h37, 6'h3F, 6'h2C, 6'h30};
        logic [5:0] a;
        foreach (mem[i]) mem[i] = 8'h00;
        repeat (2) @(negedge CLK);
        do_reset();
        repeat (4 * H) @(negedge CLK);
        fill(1);
        frame(8'h80, -1, -1);
        dq = '{8'h08};
        frame(8'h2D, -1, -1);
        dq = '{8'h01};
        frame(8'h31, -1, -1);
        chk("powerCtl_08", 16'(powerCtl), 16'h0008);
        chk("dataFormat_01", 16'(dataFormat), 16'h0001);
        xAxis = 10'h1F3;
        yAxis = 10'h200;
        zAxis = 10'h005;
        fill(6);
        frame(8'hF2, -1, -1);
        fill(2);
        frame(8'hFF, -1, -1);
        dq = '{8'h55};
        frame(8'h2D, 4, -1);
        chk("powerCtl_abort", 16'(powerCtl), 16'h0008);
        dq = '{8'hA5};
        frame(8'h2D, -1, -1);
        chk("powerCtl_A5", 16'(powerCtl), 16'h00A5);
        fill(1);
        frame(8'h80, -1, 4);
        chk("powerCtl_after_rst", 16'(powerCtl), 16'h0000);
        fill(1);
        frame(8'h80, -1, -1);
        for (int t = 0; t < 24; t++) begin
            a = ($urandom_range(0, 1) == 0) ? hot[$urandom_range(0, 14)] : 6'($urandom);
            xAxis = 10'($urandom);
            yAxis = 10'($urandom);
            zAxis = 10'($urandom);
            fill($urandom_range(1, 4));
            frame({1'($urandom), 1'($urandom), a}, -1, -1);
        end
        repeat (8 * H) @(negedge CLK);
        chk("rd_left", 16'(exp_rd.size()), 16'h0);
        chk("wr_left", 16'(exp_wr.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
